// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the RAM port arbiter.
//               - arb_state_t    : arbiter FSM state (IDLE / GRANT)
//               - lock_cnt_width : width of the burst lock counter
//               - c_default_aw/dw: default bus widths shared with CPU top
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_default_aw = 16;
    localparam int c_default_dw = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Counter must hold the value LOCK_MAX itself.
    function automatic int lock_cnt_width(input int lock_max);
        return (lock_max < 1) ? 1 : $clog2(lock_max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester-side and RAM-side bus of the memory arbiter.
//               Requester side : req, lock, we, addr, wdata (in to arbiter)
//                                gnt, rvalid, rdata        (out of arbiter)
//               RAM side       : mem_we, mem_addr, mem_in  (out of arbiter)
//                                mem_out                   (in to arbiter)
//               slave  modport : the arbiter
//               master modport : requesters plus RAM model
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int AW    = 16,
    parameter int DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_in;
    logic [DW-1:0]       mem_out;

    modport slave (
        input  req, lock, we, addr, wdata, mem_out,
        output gnt, rvalid, rdata, mem_we, mem_addr, mem_in
    );

    modport master (
        output req, lock, we, addr, wdata, mem_out,
        input  gnt, rvalid, rdata, mem_we, mem_addr, mem_in
    );
endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational rotate-priority encoder. Returns the first set
//               bit of 'eligible' searching upward from 'ptr', wrapping.
//               eligible : N candidate flags
//               ptr      : index with highest priority
//               onehot   : selected candidate, one-hot (0 if none)
//               index    : selected candidate index
//               valid    : any candidate eligible
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          valid
);

    int w_slot;

    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        w_slot = 0;
        for (int k = 0; k < N; k++) begin
            w_slot = (int'(ptr) + k) % N;
            if (!valid && eligible[w_slot]) begin
                valid          = 1'b1;
                index          = IW'(w_slot);
                onehot[w_slot] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one synchronous-read RAM port
//               between N_REQ requesters, with registered one-hot grants and
//               a bounded burst lock.
//               clk, rst : clock, synchronous active-high reset
//               bus      : mem_arbiter_if.slave (requester + RAM signals)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int AW       = c_default_aw,
    parameter int DW       = c_default_dw,
    parameter int LOCK_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int c_iw = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cw = lock_cnt_width(LOCK_MAX);

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_rvalid, w_rvalid_nxt;
    logic [c_iw-1:0]  r_owner, w_owner_nxt;
    logic [c_iw-1:0]  r_ptr, w_ptr_nxt;
    logic [c_cw-1:0]  r_cnt, w_cnt_nxt;
    logic [AW-1:0]    r_last_addr;
    logic [DW-1:0]    r_last_wdata;

    logic             w_granted;
    logic             w_own_req;
    logic             w_own_we;
    logic [AW-1:0]    w_own_addr;
    logic [DW-1:0]    w_own_wdata;
    logic [N_REQ-1:0] w_others;
    logic             w_forced;
    logic             w_keep;
    logic [N_REQ-1:0] w_pick_onehot;
    logic [c_iw-1:0]  w_pick_idx;
    logic             w_pick_valid;

    // Owner's request fields for the current grant cycle.
    assign w_granted   = (r_state == GRANT);
    assign w_own_req   = bus.req[r_owner];
    assign w_own_we    = bus.we[r_owner];
    assign w_own_addr  = bus.addr[r_owner*AW +: AW];
    assign w_own_wdata = bus.wdata[r_owner*DW +: DW];

    // r_gnt is zero when idle, so every requester is a candidate then.
    assign w_others = bus.req & ~r_gnt;
    assign w_forced = (r_cnt == c_cw'(LOCK_MAX)) && (|w_others);
    // A locked owner keeps the port ahead of the rotation; otherwise the
    // rotation would hand the port away on every pending request and a
    // burst could never run back-to-back.
    assign w_keep   = w_granted && w_own_req && bus.lock[r_owner] && !w_forced;

    rr_picker #(
        .N  (N_REQ),
        .IW (c_iw)
    ) u_picker (
        .eligible (w_others),
        .ptr      (r_ptr),
        .onehot   (w_pick_onehot),
        .index    (w_pick_idx),
        .valid    (w_pick_valid)
    );

    always_comb begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_rvalid_nxt = (w_granted && w_own_req && !w_own_we) ? r_gnt : '0;
        if (w_keep) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = r_gnt;
            // Saturate so a long uncontested burst keeps its lock.
            if (r_cnt != c_cw'(LOCK_MAX)) begin
                w_cnt_nxt = r_cnt + c_cw'(1);
            end
        end else if (w_pick_valid) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = w_pick_onehot;
            w_owner_nxt = w_pick_idx;
            w_cnt_nxt   = c_cw'(1);
            w_ptr_nxt   = (w_pick_idx == c_iw'(N_REQ - 1)) ? '0 : w_pick_idx + c_iw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_granted) begin
                r_last_addr  <= w_own_addr;
                r_last_wdata <= w_own_wdata;
            end
        end
    end

    // RAM side follows the owner in grant cycles and parks on the last
    // driven address/data when idle.
    assign bus.gnt      = r_gnt;
    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = bus.mem_out;
    assign bus.mem_we   = w_granted && w_own_req && w_own_we;
    assign bus.mem_addr = w_granted ? w_own_addr : r_last_addr;
    assign bus.mem_in   = w_granted ? w_own_wdata : r_last_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a 256-word RAM model
//               and a cycle-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N     = 2;
    localparam int AW    = c_default_aw;
    localparam int DW    = c_default_dw;
    localparam int LM    = 4;
    localparam int BOUND = (N - 1) * LM + 1;

    logic clk;
    logic rst;

    mem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .N_REQ    (N),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- stimulus drivers ----------------
    logic [N-1:0]  t_req, t_lock, t_we;
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];

    assign bus.req  = t_req;
    assign bus.lock = t_lock;
    assign bus.we   = t_we;
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign bus.addr[gi*AW +: AW]  = t_addr[gi];
        assign bus.wdata[gi*DW +: DW] = t_wdata[gi];
    end

    // ---------------- RAM model (sync read) ----------------
    logic [DW-1:0] ram [256];
    logic [DW-1:0] mem_out_r;
    assign bus.mem_out = mem_out_r;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_in;
        end
        mem_out_r <= ram[bus.mem_addr[7:0]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    int            n_chk, n_fail;
    int            m_owner, m_prev_owner, m_ptr, m_cnt, m_rv;
    logic [DW-1:0] m_rv_data;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_wdata;
    logic [DW-1:0] shadow [256];
    int            waited [N];

    logic [N-1:0]  obs_gnt, obs_rvalid;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_in, obs_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_prev_owner = -1; m_ptr = 0; m_cnt = 0; m_rv = -1;
        m_rv_data = '0; m_last_addr = '0; m_last_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        for (int j = 0; j < N; j++) waited[j] = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [N-1:0]  e_gnt, e_rv;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_in;
        int            o, found, j;
        bit            others;
        @(negedge clk);
        obs_gnt = bus.gnt; obs_rvalid = bus.rvalid; obs_we = bus.mem_we;
        obs_addr = bus.mem_addr; obs_in = bus.mem_in; obs_rdata = bus.rdata;
        o = m_owner;
        e_gnt = '0; e_rv = '0;
        if (o >= 0) begin
            e_gnt[o] = 1'b1;
            e_we     = t_req[o] & t_we[o];
            e_addr   = t_addr[o];
            e_in     = t_wdata[o];
        end else begin
            e_we = 1'b0; e_addr = m_last_addr; e_in = m_last_wdata;
        end
        if (m_rv >= 0) e_rv[m_rv] = 1'b1;
        chk("gnt", 32'(obs_gnt), 32'(e_gnt));
        chk("rvalid", 32'(obs_rvalid), 32'(e_rv));
        chk("mem_we", 32'(obs_we), 32'(e_we));
        chk("mem_addr", 32'(obs_addr), 32'(e_addr));
        chk("mem_in", 32'(obs_in), 32'(e_in));
        if (m_rv >= 0) chk("rdata", 32'(obs_rdata), 32'(m_rv_data));
        for (int k = 0; k < N; k++) begin
            if (!rst && t_req[k] && o != k) waited[k]++;
            else waited[k] = 0;
            if (waited[k] > 0) chk("starve_bound", (waited[k] <= BOUND) ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk);
        m_prev_owner = o;
        if (rst) begin
            model_reset();
        end else begin
            m_rv = -1;
            if (o >= 0) begin
                m_last_addr = t_addr[o]; m_last_wdata = t_wdata[o];
                if (t_req[o]) begin
                    if (t_we[o]) shadow[t_addr[o][7:0]] = t_wdata[o];
                    else begin m_rv = o; m_rv_data = shadow[t_addr[o][7:0]]; end
                end
            end
            others = 1'b0;
            for (int k = 0; k < N; k++) if (k != o && t_req[k]) others = 1'b1;
            if (o >= 0 && t_req[o] && t_lock[o] && !(m_cnt == LM && others)) begin
                if (m_cnt < LM) m_cnt++;
            end else begin
                found = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (found < 0 && j != o && t_req[j]) found = j;
                end
                if (found >= 0) begin
                    m_owner = found; m_ptr = (found + 1) % N; m_cnt = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        #1;
    endtask

    task automatic set_acc(input int i, input bit r, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[i] = r; t_we[i] = w; t_lock[i] = l; t_addr[i] = a; t_wdata[i] = d;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int run;
        n_chk = 0; n_fail = 0;
        rst = 1'b1;
        t_req = '1; t_lock = '0; t_we = '0;
        for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
        model_reset();
        @(posedge clk); #1;

        // Reset held with all requests high.
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_gnt", 32'(obs_gnt), 32'd0);
        chk("post_rst_rvalid", 32'(obs_rvalid), 32'd0);
        t_req = '0;
        repeat (2) cycle();

        // Single write then read-back by requester 1.
        set_acc(1, 1, 1, 0, 16'h0010, 16'hBEEF);
        cycle();
        cycle();
        chk("wr_gnt", 32'(obs_gnt), 32'h2);
        chk("wr_mem_we", 32'(obs_we), 32'd1);
        chk("wr_mem_addr", 32'(obs_addr), 32'h0010);
        chk("wr_mem_in", 32'(obs_in), 32'hBEEF);
        t_we[1] = 1'b0;
        cycle();
        cycle();
        t_req = '0;
        cycle();
        chk("rd_rvalid", 32'(obs_rvalid), 32'h2);
        chk("rd_rdata", 32'(obs_rdata), 32'hBEEF);

        // Fairness: both requesting, no lock.
        set_acc(0, 1, 0, 0, 16'h0001, 16'h0);
        set_acc(1, 1, 0, 0, 16'h0010, 16'h0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fair_seq", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        t_req = '0;
        repeat (2) cycle();

        // Lock bound with requester 1 pending, then saturation with it idle.
        set_acc(0, 1, 0, 1, 16'h0010, 16'h0);
        cycle();
        set_acc(1, 1, 0, 0, 16'h0020, 16'h0);
        run = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (obs_gnt == 2'b01) run++;
            else break;
        end
        chk("lock_run", 32'(run), 32'd4);
        chk("lock_release", 32'(obs_gnt), 32'h2);
        t_req[1] = 1'b0;
        run = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_gnt == 2'b01) run++;
        end
        chk("lock_sat_run", 32'(run), 32'd8);
        t_req = '0; t_lock = '0;
        repeat (2) cycle();

        // Withdrawal of a write in its grant cycle.
        set_acc(1, 1, 1, 0, 16'h0020, 16'h1234);
        cycle();
        cycle();
        set_acc(1, 1, 1, 0, 16'h0020, 16'hDEAD);
        cycle();
        t_req = '0;
        cycle();
        chk("wd_gnt", 32'(obs_gnt), 32'h2);
        chk("wd_mem_we", 32'(obs_we), 32'd0);
        cycle();
        chk("wd_rvalid", 32'(obs_rvalid), 32'd0);
        set_acc(1, 1, 0, 0, 16'h0020, 16'h0);
        cycle();
        cycle();
        t_req = '0;
        cycle();
        chk("wd_readback", 32'(obs_rdata), 32'h1234);

        // Reset during a read's grant cycle.
        set_acc(1, 1, 0, 0, 16'h0010, 16'h0);
        cycle();
        rst = 1'b1;
        cycle();
        chk("rstrd_gnt", 32'(obs_gnt), 32'h2);
        rst = 1'b0;
        t_req = '0;
        cycle();
        chk("rstrd_rvalid", 32'(obs_rvalid), 32'd0);
        chk("rstrd_gnt_after", 32'(obs_gnt), 32'd0);
        cycle();

        // Randomized traffic; inputs change only after service or while idle.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N; j++) begin
                if (m_prev_owner == j || (!t_req[j] && $urandom_range(0, 2) == 0)) begin
                    set_acc(j, (m_prev_owner == j) ? ($urandom_range(0, 3) != 0) : 1'b1,
                            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                            AW'($urandom_range(0, 15)), DW'($urandom));
                end
                if (m_owner == j && t_req[j] && $urandom_range(0, 9) == 0) t_req[j] = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous-read RAM port between N_REQ requesters: CPU data port, program loader, display scanner.
- Round-robin arbitration with registered grants and optional bounded lock for bursts.
- Sits between the requesters and the RAM. Drives mem_we/mem_addr/mem_in and returns mem_out to the access owner with a read-valid strobe.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- AW, 16, address width
- DW, 16, data width
- LOCK_MAX, 4, max consecutive grants to one locked requester while another request is pending (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester access request; inputs held stable until grant
- lock  in  N_REQ  requester has another access for the following cycle (burst)
- we  in  N_REQ  1 = write, 0 = read
- addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- wdata  in  N_REQ*DW  packed write data
- gnt  out  N_REQ  one-hot registered grant; access performed in cycles with gnt[i]&req[i]
- rvalid  out  N_REQ  read data valid for requester i
- rdata  out  DW  shared read data (equals mem_out)
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_in  out  DW  RAM write data
- mem_out  in  DW  RAM read data, valid one cycle after address

Behaviour:
- Reset values: gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_in=0, rr pointer=0, lock count=0, state IDLE. rst wins over every other event.
- States:
  - IDLE: no grant.
  - GRANT: gnt one-hot for exactly one cycle per access.
- Transitions are evaluated every edge.
- Arbitration in cycle t selects the owner for cycle t+1, so the grant has 1-cycle latency from req.
- Eligibility: req[j]=1 for every non-grantee j. The current grantee i is eligible only if lock[i]=1 and no forced release applies.
- Selection: the first eligible index searching upward from the rr pointer, wrapping modulo N_REQ. On each new grant to a different requester, the pointer becomes (winner+1) mod N_REQ.
- Consequence: an unlocked requester gets at most every other cycle. A locked burst gets back-to-back cycles.
- Lock count:
  - Increments on each consecutive grant to the same requester; resets to 1 on a grant to a new requester.
  - Forced release when count==LOCK_MAX and any other req is pending. If no other req is pending, the lock continues and the count saturates.
- No eligible requester → next state IDLE, gnt=0.
- Grant-cycle outputs (combinational from the owner's inputs):
  - mem_addr = addr[owner], mem_in = wdata[owner].
  - mem_we = we[owner] & req[owner].
- Withdrawal: if req[owner]=0 during its gnt cycle, the access is cancelled. mem_we=0 and no rvalid follows.
- Idle cycles: mem_addr and mem_in hold their last values; mem_we=0.
- Read return:
  - rvalid[owner] asserts in cycle t+1 for a read performed in cycle t (gnt&req&~we), with rdata=mem_out. This is a 2-cycle latency from req to rvalid.
  - rvalid is one-hot or zero.
  - Back-to-back locked reads produce consecutive rvalid.
- Reset mid-operation: any pending rvalid is suppressed; the grant is dropped the cycle after rst.
- Starvation bound: a continuously requesting requester is granted within (N_REQ-1)*LOCK_MAX+1 cycles.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - a helper function for the lock-counter width, clog2(LOCK_MAX+1);
  - default AW/DW constants shared with the CPU top.
- One sub-module, rr_picker: combinational rotate-priority encoder with inputs eligible[N_REQ] and pointer, outputs onehot and index and valid. It is reusable for future register-file port sharing.

Test Plan:
- Reset: hold rst 3 cycles with all req=1 → gnt=0, rvalid=0, mem_we=0 throughout, and on the first cycle after release.
- Single write/read:
  - req[1], we=1, addr=0x0010, wdata=0xBEEF → next cycle gnt=2'b10, mem_we=1, mem_addr=0x0010, mem_in=0xBEEF.
  - Then a read of 0x0010 → rvalid[1]=1 and rdata=0xBEEF two cycles after req.
- Fairness, N_REQ=2: both req held high, lock=0 → gnt sequence 01,10,01,10. No cycle has both bits set.
- Lock bound, LOCK_MAX=4: req0 locked, req1 pending → gnt0 for 4 consecutive cycles, then gnt1. With req1 low, gnt0 continues beyond 4 cycles.
- Withdrawal: req1 drops in its gnt cycle with we=1 → mem_we=0 that cycle, memory unchanged, no rvalid.
- Reset mid-read: rst asserted in the read's gnt cycle → rvalid stays 0 next cycle and gnt=0 after reset.
